// File: rtl/gray_pkg.sv
// Shared definitions for the Gray encoder and its decoder-side consumers.
//   - state_e    : encoder FSM states
//   - DEC_MAX    : default highest legal decimal digit
//   - GRAY_WIDTH : default digit / Gray word width
//   - bin2gray() : binary-to-Gray conversion. It works on a 32-bit container,
//                  so callers narrow the result to their own WIDTH.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;
    localparam int DEC_MAX    = 9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/dec_to_gray_encoder_if.sv
// Handshake bundle between a digit source / Gray sink and the encoder.
//   slave  : encoder side (consumes digits, produces Gray words)
//   master : environment side
// Signals: in_valid/in_ready/in_dec (digit input), sweep_start/sweep_busy,
//          out_valid/out_ready/out_gray/out_err (Gray output)
interface dec_to_gray_encoder_if #(parameter int WIDTH = 4);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dec;
    logic             sweep_start;
    logic             sweep_busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gray;
    logic             out_err;

    modport slave (
        input  in_valid, in_dec, sweep_start, out_ready,
        output in_ready, sweep_busy, out_valid, out_gray, out_err
    );

    modport master (
        output in_valid, in_dec, sweep_start, out_ready,
        input  in_ready, sweep_busy, out_valid, out_gray, out_err
    );

endinterface

// File: rtl/gray_out_stage.sv
// Single-entry valid/ready output register carrying a Gray word and its error flag.
// Ports: i_clk, i_rst (async active-high), i_load (write a new entry),
//        i_data/i_err (entry contents), i_ready (downstream accepts),
//        o_valid/o_data/o_err (registered entry).
// The caller only raises i_load when the entry is free or is being taken
// this cycle, so a load never overwrites a word that has not transferred.
module gray_out_stage #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_err,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_err
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    // Entry register: load new word, or empty it once the word is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_err   <= i_err;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_err   = r_err;

endmodule

// File: rtl/dec_to_gray_encoder.sv
// Decimal-digit to Gray encoder with an auto-sweep mode for decoder bring-up.
// Ports: clk, rst (async active-high), bus (slave modport of dec_to_gray_encoder_if).
//   Digit path: an accepted digit appears as a registered Gray word one cycle later.
//               Digits above MAX_DEC produce Gray 0 with out_err set.
//   Sweep path: a sweep_start pulse in IDLE emits gray(0..MAX_DEC) once, in order,
//               honouring backpressure. sweep_busy is high while words remain to load.
module dec_to_gray_encoder
    import gray_pkg::*;
#(
    parameter int WIDTH   = GRAY_WIDTH,
    parameter int MAX_DEC = DEC_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    dec_to_gray_encoder_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_DEC);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    logic             w_stage_free;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_sweep_load;
    logic             w_load;
    logic [WIDTH-1:0] w_data;
    logic             w_err;

    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_gray;
    logic             w_out_err;

    // The output entry can take a word when empty or being drained this cycle.
    assign w_stage_free = !w_out_valid || bus.out_ready;
    assign w_in_ready   = (r_state == IDLE) && !bus.sweep_start && w_stage_free;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_sweep_load = (r_state == SWEEP) && w_stage_free;

    // State register and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the last sweep word returns to IDLE on the edge it loads.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.sweep_start) begin
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SWEEP: begin
                if (w_sweep_load && (r_cnt == MAX_W)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_sweep_load) begin
                    w_cnt_nxt   = r_cnt + WIDTH'(1);
                end else begin
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: select the word to load and range-check accepted digits.
    always_comb begin
        w_load = w_accept || w_sweep_load;
        w_data = '0;
        w_err  = 1'b0;
        if (r_state == SWEEP) begin
            w_data = WIDTH'(bin2gray(32'(r_cnt)));
            w_err  = 1'b0;
        end else if (bus.in_dec > MAX_W) begin
            w_data = '0;
            w_err  = 1'b1;
        end else begin
            w_data = WIDTH'(bin2gray(32'(bus.in_dec)));
            w_err  = 1'b0;
        end
    end

    gray_out_stage #(.WIDTH(WIDTH)) u_out_stage (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_data  (w_data),
        .i_err   (w_err),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_gray),
        .o_err   (w_out_err)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.sweep_busy = (r_state == SWEEP);
    assign bus.out_valid  = w_out_valid;
    assign bus.out_gray   = w_out_gray;
    assign bus.out_err    = w_out_err;

endmodule
